// File: rtl/sme_ks_rng.sv
// Keccak-f[400] randomness source: one round per cycle, ROUNDS-cycle permutation, state exposed as s_rng.
// rng_valid is a one-shot handshake consumed by req; seeding preempts consumption and restarts the permutation.
module sme_ks_rng #(
    parameter int KS     = 400,
    parameter int ROUNDS = 20
) (
    input  logic          g_clk,
    input  logic          g_resetn,
    input  logic          seed_valid,
    input  logic [31:0]   seed_data,
    output logic          seed_ready,
    input  logic          req,
    output logic          rng_valid,
    output logic [KS-1:0] s_rng,
    output logic          busy
);
    localparam int LW     = KS / 25;
    localparam int NWORDS = 13;

    if (KS != 400) begin : g_bad_ks
        $error("sme_ks_rng: KS must be 400");
    end
    if (ROUNDS < 1 || ROUNDS > 20) begin : g_bad_rounds
        $error("sme_ks_rng: ROUNDS must be in 1..20");
    end

    // Keccak rho offsets mod 16, indexed by lane x+5y
    localparam int RHO [25] = '{ 0,  1, 14, 12, 11,
                                 4, 12,  6,  7,  4,
                                 3, 10, 11,  9,  7,
                                 9, 13, 15,  5,  8,
                                 2,  2, 13,  8, 14};

    typedef enum logic [1:0] {PERMUTE, READY, SEED} fsm_e;

    function automatic logic [LW-1:0] rotl(input logic [LW-1:0] v, input int n);
        logic [2*LW-1:0] t;
        t = {v, v} << n;
        return t[2*LW-1:LW];
    endfunction

    function automatic logic [LW-1:0] rc16(input logic [4:0] r);
        case (r)
            5'd0:    return 16'h0001;
            5'd1:    return 16'h8082;
            5'd2:    return 16'h808A;
            5'd3:    return 16'h8000;
            5'd4:    return 16'h808B;
            5'd5:    return 16'h0001;
            5'd6:    return 16'h8081;
            5'd7:    return 16'h8009;
            5'd8:    return 16'h008A;
            5'd9:    return 16'h0088;
            5'd10:   return 16'h8009;
            5'd11:   return 16'h000A;
            5'd12:   return 16'h808B;
            5'd13:   return 16'h008B;
            5'd14:   return 16'h8089;
            5'd15:   return 16'h8003;
            5'd16:   return 16'h8002;
            5'd17:   return 16'h0080;
            5'd18:   return 16'h800A;
            5'd19:   return 16'h000A;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic [KS-1:0] ks_round(input logic [KS-1:0] s, input logic [LW-1:0] rc);
        logic [LW-1:0] a [25];
        logic [LW-1:0] b [25];
        logic [LW-1:0] c [5];
        logic [LW-1:0] d [5];
        logic [KS-1:0] r;
        r = '0;
        for (int i = 0; i < 25; i++) a[i] = s[LW*i +: LW];
        for (int x = 0; x < 5; x++) c[x] = a[x] ^ a[x+5] ^ a[x+10] ^ a[x+15] ^ a[x+20];
        for (int x = 0; x < 5; x++) d[x] = c[(x+4)%5] ^ rotl(c[(x+1)%5], 1);
        for (int i = 0; i < 25; i++) a[i] = a[i] ^ d[i%5];
        // rho and pi fused: lane (x,y) lands at (y, 2x+3y)
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                b[y + 5*((2*x + 3*y) % 5)] = rotl(a[x + 5*y], RHO[x + 5*y]);
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                r[LW*(x + 5*y) +: LW] = b[x + 5*y] ^ (~b[(x+1)%5 + 5*y] & b[(x+2)%5 + 5*y]);
        r[LW-1:0] = r[LW-1:0] ^ rc;
        return r;
    endfunction

    logic [KS-1:0] state_q, round_d, seed_d;
    logic [4:0]    rnd_q;
    logic [3:0]    ptr_q, ptr_d;
    fsm_e          fsm_q;
    logic          rng_valid_q, busy_q, seed_ready_q;

    assign round_d = ks_round(state_q, rc16(rnd_q));
    // word 12 straddles the top of the state, so the shift drops seed_data[31:16]
    assign seed_d  = state_q ^ (KS'(seed_data) << (32 * ptr_q));
    assign ptr_d   = (ptr_q == 4'(NWORDS-1)) ? 4'd0 : ptr_q + 4'd1;

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            state_q      <= '0;
            rnd_q        <= '0;
            ptr_q        <= '0;
            fsm_q        <= PERMUTE;
            rng_valid_q  <= 1'b0;
            busy_q       <= 1'b1;
            seed_ready_q <= 1'b0;
        end else begin
            case (fsm_q)
                PERMUTE: begin
                    state_q <= round_d;
                    if (rnd_q == 5'(ROUNDS-1)) begin
                        rnd_q        <= '0;
                        fsm_q        <= READY;
                        rng_valid_q  <= 1'b1;
                        busy_q       <= 1'b0;
                        seed_ready_q <= 1'b1;
                    end else begin
                        rnd_q <= rnd_q + 5'd1;
                    end
                end
                READY: begin
                    if (seed_valid) begin
                        state_q     <= seed_d;
                        ptr_q       <= ptr_d;
                        fsm_q       <= SEED;
                        rng_valid_q <= 1'b0;
                    end else if (req && rng_valid_q) begin
                        fsm_q        <= PERMUTE;
                        rng_valid_q  <= 1'b0;
                        busy_q       <= 1'b1;
                        seed_ready_q <= 1'b0;
                    end
                end
                SEED: begin
                    if (seed_valid) begin
                        state_q <= seed_d;
                        ptr_q   <= ptr_d;
                    end else begin
                        fsm_q        <= PERMUTE;
                        busy_q       <= 1'b1;
                        seed_ready_q <= 1'b0;
                    end
                end
                default: fsm_q <= PERMUTE;
            endcase
        end
    end

    assign s_rng      = state_q;
    assign rng_valid  = rng_valid_q;
    assign busy       = busy_q;
    assign seed_ready = seed_ready_q;

endmodule

// File: tb/tb_sme_ks_rng.sv
// Bench for sme_ks_rng: array-based Keccak-f[400] model with LFSR-derived round constants,
// driving warm-up, consume, seeding, collisions, random traffic and a mid-permutation reset.
module tb_sme_ks_rng;
    localparam int KS = 400;

    logic          g_clk = 1'b0;
    logic          g_resetn;
    logic          seed_valid;
    logic [31:0]   seed_data;
    logic          seed_ready;
    logic          req;
    logic          rng_valid;
    logic [KS-1:0] s_rng;
    logic          busy;

    int            n_checks = 0;
    int            n_errors = 0;
    logic [KS-1:0] m_state;
    int            m_ptr;

    sme_ks_rng #(.KS(400), .ROUNDS(20)) dut (
        .g_clk      (g_clk),
        .g_resetn   (g_resetn),
        .seed_valid (seed_valid),
        .seed_data  (seed_data),
        .seed_ready (seed_ready),
        .req        (req),
        .rng_valid  (rng_valid),
        .s_rng      (s_rng),
        .busy       (busy)
    );

    always #5 g_clk = ~g_clk;

    task automatic check(input string tag, input logic [KS-1:0] got, input logic [KS-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Keccak LFSR rc(t) over x^8+x^6+x^5+x^4+1
    function automatic bit rc_bit(input int t);
        logic [7:0] r;
        logic [8:0] r9;
        int         m;
        m = t % 255;
        r = 8'h01;
        for (int i = 1; i <= m; i++) begin
            r9    = {r, 1'b0};
            r9[0] = r9[0] ^ r9[8];
            r9[4] = r9[4] ^ r9[8];
            r9[5] = r9[5] ^ r9[8];
            r9[6] = r9[6] ^ r9[8];
            r     = r9[7:0];
        end
        return r[0];
    endfunction

    function automatic logic [15:0] rol(input logic [15:0] v, input int n);
        logic [15:0] t;
        t = v;
        for (int k = 0; k < n; k++) t = {t[14:0], t[15]};
        return t;
    endfunction

    function automatic logic [KS-1:0] keccak_f(input logic [KS-1:0] s);
        logic [15:0]   a [5][5];
        logic [15:0]   b [5][5];
        logic [15:0]   c [5];
        logic [15:0]   d [5];
        logic [15:0]   rcw;
        logic [KS-1:0] o;
        int            rho [5][5];
        int            px, py, tmp;
        rho[0][0] = 0;
        px = 1; py = 0;
        for (int t = 0; t < 24; t++) begin
            rho[px][py] = ((t + 1) * (t + 2) / 2) % 16;
            tmp = py;
            py  = (2 * px + 3 * py) % 5;
            px  = tmp;
        end
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++) a[x][y] = s[16*(x+5*y) +: 16];
        for (int ir = 0; ir < 20; ir++) begin
            for (int x = 0; x < 5; x++) c[x] = a[x][0] ^ a[x][1] ^ a[x][2] ^ a[x][3] ^ a[x][4];
            for (int x = 0; x < 5; x++) d[x] = c[(x+4)%5] ^ rol(c[(x+1)%5], 1);
            for (int x = 0; x < 5; x++)
                for (int y = 0; y < 5; y++) a[x][y] = a[x][y] ^ d[x];
            for (int x = 0; x < 5; x++)
                for (int y = 0; y < 5; y++) b[y][(2*x+3*y)%5] = rol(a[x][y], rho[x][y]);
            for (int x = 0; x < 5; x++)
                for (int y = 0; y < 5; y++) a[x][y] = b[x][y] ^ (~b[(x+1)%5][y] & b[(x+2)%5][y]);
            rcw = '0;
            for (int j = 0; j <= 4; j++) rcw[(1 << j) - 1] = rc_bit(j + 7 * ir);
            a[0][0] = a[0][0] ^ rcw;
        end
        o = '0;
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++) o[16*(x+5*y) +: 16] = a[x][y];
        return o;
    endfunction

    function automatic logic [KS-1:0] seed_xor(input logic [KS-1:0] s, input int ptr, input logic [31:0] w);
        logic [KS-1:0] o;
        o = s;
        for (int k = 0; k < 32; k++)
            if (32 * ptr + k < KS) o[32*ptr + k] = o[32*ptr + k] ^ w[k];
        return o;
    endfunction

    // Counts busy samples until rng_valid, starting at the current negedge.
    task automatic wait_valid(input bit noise, output int nbusy);
        int overlap;
        bit done;
        overlap = 0;
        done    = 1'b0;
        nbusy   = 0;
        for (int k = 0; k < 200 && !done; k++) begin
            if (rng_valid && busy) overlap++;
            if (rng_valid) begin
                done = 1'b1;
            end else begin
                if (busy) nbusy++;
                if (noise) req = 1'($urandom_range(0, 1));
                @(negedge g_clk);
            end
        end
        req = 1'b0;
        if (!done) nbusy = -1;
        check("valid_busy_overlap", KS'(overlap), '0);
    endtask

    task automatic finish_perm(input string tag, input bit noise);
        int nb;
        wait_valid(noise, nb);
        check({tag, "_busy_cycles"}, KS'(nb), KS'(20));
        m_state = keccak_f(m_state);
        check({tag, "_state"}, s_rng, m_state);
        check({tag, "_seed_ready"}, KS'(seed_ready), KS'(1));
    endtask

    task automatic consume(input bit noise);
        req = 1'b1;
        @(negedge g_clk);
        req = 1'b0;
        check("consume_valid_drop", KS'(rng_valid), '0);
        check("consume_busy", KS'(busy), KS'(1));
        finish_perm("consume", noise);
    endtask

    task automatic seed_burst(input int n, input bit rand_data, input logic [31:0] word,
                              input bit with_req, input bit noise);
        logic [31:0] w;
        for (int i = 0; i < n; i++) begin
            w          = rand_data ? 32'($urandom) : word;
            seed_valid = 1'b1;
            seed_data  = w;
            req        = with_req ? ((i == 0) ? 1'b1 : 1'($urandom_range(0, 1))) : 1'b0;
            m_state    = seed_xor(m_state, m_ptr, w);
            m_ptr      = (m_ptr + 1) % 13;
            @(negedge g_clk);
            check("seed_absorb_state", s_rng, m_state);
            check("seed_valid_low", KS'(rng_valid), '0);
            check("seed_ready_high", KS'(seed_ready), KS'(1));
        end
        seed_valid = 1'b0;
        seed_data  = '0;
        req        = 1'b0;
        @(negedge g_clk);
        finish_perm("seed", noise);
    endtask

    initial begin
        int nb;
        logic [KS-1:0] hold;
        g_resetn   = 1'b0;
        seed_valid = 1'b0;
        seed_data  = '0;
        req        = 1'b0;
        m_state    = '0;
        m_ptr      = 0;

        repeat (3) @(negedge g_clk);
        check("rst_busy", KS'(busy), KS'(1));
        check("rst_valid", KS'(rng_valid), '0);
        check("rst_seed_ready", KS'(seed_ready), '0);
        check("rst_state", s_rng, '0);

        // warm-up: busy for 20 samples beginning with the reset-edge sample
        g_resetn = 1'b1;
        finish_perm("warmup", 1'b0);
        check("ready_busy_low", KS'(busy), '0);

        consume(1'b0);
        hold = s_rng;
        repeat ($urandom_range(2, 8)) @(negedge g_clk);
        check("stable_state", s_rng, hold);
        check("stable_valid", KS'(rng_valid), KS'(1));

        seed_burst(1, 1'b0, 32'h0000_0001, 1'b0, 1'b0);
        seed_burst(14, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0);

        // seed and req together: seed wins, reqs during SEED/PERMUTE do nothing
        seed_burst(3, 1'b1, 32'h0, 1'b1, 1'b1);

        for (int it = 0; it < 8; it++) begin
            if ($urandom_range(0, 1) == 0) consume(1'b1);
            else seed_burst(int'($urandom_range(1, 5)), 1'b1, 32'h0, 1'($urandom_range(0, 1)), 1'b1);
        end

        // reset while rnd == 7
        req = 1'b1;
        @(negedge g_clk);
        req = 1'b0;
        repeat (7) @(negedge g_clk);
        g_resetn = 1'b0;
        @(negedge g_clk);
        check("midrst_state", s_rng, '0);
        check("midrst_valid", KS'(rng_valid), '0);
        check("midrst_busy", KS'(busy), KS'(1));
        g_resetn = 1'b1;
        m_state  = '0;
        m_ptr    = 0;
        finish_perm("rewarm", 1'b0);
        seed_burst(1, 1'b1, 32'h0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
